// File: rtl/limb_serial_adder_pkg.sv
// Shared types and helpers for the limb-serial wide adder.
// Contents: FSM state enum lsa_state_t and the counter-width function lsa_cnt_w.
// No logic of its own; imported by the top module.
package lsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lsa_state_t;

  // Limb counter width; never zero so a single-limb build still has a real register.
  function automatic int lsa_cnt_w(input int limbs);
    return (limbs > 1) ? $clog2(limbs) : 1;
  endfunction

endpackage

// File: rtl/limb_serial_adder_if.sv
// Handshake bundle for the limb-serial adder: operand input channel and result output channel.
// Ports: in_valid/in_ready/a/b/cin (request), out_valid/out_ready/sum/cout (response), ovf under LSA_OVF_EN.
// slave modport is the adder side, master modport is the producer/consumer side.
interface limb_serial_adder_if #(
  parameter int wididx = 3,
  parameter int LIMBS  = 4
);
  localparam int N = LIMBS * (2 ** wididx);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef LSA_OVF_EN
  logic         ovf;
`endif

`ifdef LSA_OVF_EN
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
`else
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/limb_serial_adder_ksa.sv
// KSA: Kogge-Stone parallel-prefix adder of width 2**wididx with carry-in.
// Ports: A, B (operands), Cin (carry in), Sum (A+B+Cin mod 2**W), Cout (carry out).
// Purely combinational, no handshake; log2(W) prefix levels.
module KSA #(
  parameter int wididx = 3
) (
  input  logic [2**wididx-1:0] A,
  input  logic [2**wididx-1:0] B,
  input  logic                 Cin,
  output logic [2**wididx-1:0] Sum,
  output logic                 Cout
);
  localparam int W     = 2 ** wididx;
  // Group-propagate is only needed up to the second-to-last level.
  localparam int P_LVL = (wididx > 0) ? wididx : 1;

  logic [W-1:0] gl [wididx+1];
  logic [W-1:0] pl [P_LVL];
  logic [W:0]   carries;

  // Folding Cin into bit 0's generate makes every prefix G[i] the carry into bit i+1.
  assign pl[0] = A ^ B;
  assign gl[0] = (A & B) | {{(W-1){1'b0}}, (A[0] ^ B[0]) & Cin};

  for (genvar l = 0; l < wididx; l++) begin : g_level
    localparam int D = 2 ** l;
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-D]);
        if (l + 1 < wididx) begin : g_p
          assign pl[l+1][i] = pl[l][i] & pl[l][i-D];
        end
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        if (l + 1 < wididx) begin : g_p
          assign pl[l+1][i] = pl[l][i];
        end
      end
    end
  end

  assign carries = {gl[wididx], Cin};
  assign Sum     = pl[0] ^ carries[W-1:0];
  assign Cout    = carries[W];

endmodule

// File: rtl/limb_serial_adder.sv
// limb_serial_adder: wide A+B+cin computed one limb per cycle through a single KSA, carry chained in a register.
// Latency: accept at edge E0, out_valid after edge E0+LIMBS; one op per LIMBS+2 cycles. Optional ovf under LSA_OVF_EN.
// Backpressure: in_ready only in IDLE; result (sum/cout/ovf) held stable in DONE until out_ready. Ports: clk, rst, bus (slave).
module limb_serial_adder
  import lsa_pkg::*;
#(
  parameter int wididx = 3,
  parameter int LIMBS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  limb_serial_adder_if.slave  bus
);
  localparam int              W        = 2 ** wididx;
  localparam int              N        = LIMBS * W;
  localparam int              CW       = lsa_cnt_w(LIMBS);
  localparam logic [CW-1:0]   LAST_CNT = CW'(LIMBS - 1);

  lsa_state_t    state;
  lsa_state_t    state_nxt;
  logic          in_ready_c;
  logic          out_valid_c;

  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [N-1:0]  sum_reg;
  logic          cout_reg;
`ifdef LSA_OVF_EN
  logic          ovf_reg;
`endif

  logic [W-1:0]  ksa_a;
  logic [W-1:0]  ksa_b;
  logic [W-1:0]  ksa_sum;
  logic          ksa_cout;
  logic          accept;
  logic          last_limb;

  assign accept    = bus.in_valid & in_ready_c;
  assign last_limb = (cnt == LAST_CNT);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_limb) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        // No same-cycle re-accept: IDLE is a full cycle after the output handshake.
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- limb select ----------------
  assign ksa_a = a_reg[int'(cnt)*W +: W];
  assign ksa_b = b_reg[int'(cnt)*W +: W];

  KSA #(.wididx(wididx)) u_ksa (
    .A    (ksa_a),
    .B    (ksa_b),
    .Cin  (carry),
    .Sum  (ksa_sum),
    .Cout (ksa_cout)
  );

  // ---------------- datapath / write-back ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
`ifdef LSA_OVF_EN
      ovf_reg  <= 1'b0;
`endif
    end else if (accept) begin
      // Operands are sampled only here; later bus changes cannot disturb the running add.
      a_reg <= bus.a;
      b_reg <= bus.b;
      cnt   <= '0;
      carry <= bus.cin;
    end else if (state == RUN) begin
      sum_reg[int'(cnt)*W +: W] <= ksa_sum;
      carry                     <= ksa_cout;
      if (last_limb) begin
        cout_reg <= ksa_cout;
`ifdef LSA_OVF_EN
        // Signed overflow: equal operand signs but result sign differs.
        ovf_reg  <= (a_reg[N-1] ~^ b_reg[N-1]) & (ksa_sum[W-1] ^ a_reg[N-1]);
`endif
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
`ifdef LSA_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_limb_serial_adder.sv
// Self-checking bench for limb_serial_adder (LIMBS=4 and LIMBS=1 instances, wididx=3).
// Reference: plain integer addition of the full-width operands; overflow from operand/result signs.
module tb_limb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  limb_serial_adder_if #(.wididx(3), .LIMBS(4)) bus4 ();
  limb_serial_adder_if #(.wididx(3), .LIMBS(1)) bus1 ();

  limb_serial_adder #(.wididx(3), .LIMBS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  limb_serial_adder #(.wididx(3), .LIMBS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [32:0] ref_add32(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  function automatic logic ref_ovf32(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] s;
    s = ref_add32(x, y, c);
    return (x[31] == y[31]) && (s[31] != x[31]);
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Offers one operand set to the 4-limb DUT, returns cycles from accept to out_valid and the result.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        output int lat, output logic [31:0] s, output logic co);
    int guard;
    guard = 0;
    while (bus4.in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    bus4.a = av; bus4.b = bv; bus4.cin = cv; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 32) begin tick(); lat++; end
    s  = bus4.sum;
    co = bus4.cout;
  endtask

  task automatic release_out;
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus4.in_ready); end
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus4.out_valid); end
    checks++; if (bus4.sum !== 32'd0 || bus4.cout !== 1'b0) begin errors++; $display("FAIL reset_result got=%h/%b exp=0/0", bus4.sum, bus4.cout); end
    checks++; if (dut4.cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", dut4.cnt); end
    checks++; if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_l1 got=%b%b exp=10", bus1.in_ready, bus1.out_valid); end
`ifdef LSA_OVF_EN
    checks++; if (bus4.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus4.ovf); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_carry_chain;
    int lat; logic [31:0] s; logic co;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, s, co);
    checks++; if (lat !== 4) begin errors++; $display("FAIL chain_latency got=%0d exp=4", lat); end
    checks++; if (s !== 32'h0 || co !== 1'b1) begin errors++; $display("FAIL chain_result got=%h/%b exp=00000000/1", s, co); end
    checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL chain_done_in_ready got=%b exp=0", bus4.in_ready); end
    release_out();
    checks++; if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin errors++; $display("FAIL chain_idle got=%b%b exp=10", bus4.in_ready, bus4.out_valid); end
  endtask

  task automatic test_carry_in;
    int lat; logic [31:0] s; logic co;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, lat, s, co);
    checks++; if (s !== 32'h2345_678A || co !== 1'b0) begin errors++; $display("FAIL carry_in got=%h/%b exp=2345678a/0", s, co); end
    release_out();
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] s; logic co; logic [31:0] av, bv; logic [32:0] r;
    av = $urandom; bv = $urandom;
    r = ref_add32(av, bv, 1'b0);
    run_op(av, bv, 1'b0, lat, s, co);
    checks++; if ({co, s} !== r) begin errors++; $display("FAIL bp_result got=%b/%h exp=%b/%h", co, s, r[32], r[31:0]); end
    for (int i = 0; i < 5; i++) begin
      bus4.a = $urandom; bus4.b = $urandom; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
      tick();
      checks++;
      if (bus4.sum !== r[31:0] || bus4.cout !== r[32] || bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got sum=%h cout=%b rdy=%b vld=%b exp sum=%h cout=%b rdy=0 vld=1",
                 i, bus4.sum, bus4.cout, bus4.in_ready, bus4.out_valid, r[31:0], r[32]);
      end
    end
    bus4.in_valid = 1'b0;
    release_out();
    checks++; if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b%b exp=10", bus4.in_ready, bus4.out_valid); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] s; logic co; logic [31:0] av, bv; logic [32:0] r;
    bus4.a = 32'hDEAD_BEEF; bus4.b = 32'h0BAD_F00D; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick(); tick();
    checks++; if (dut4.cnt !== 2'd2) begin errors++; $display("FAIL mid_cnt got=%0d exp=2", dut4.cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.sum !== 32'h0 || bus4.cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b vld=%b sum=%h cout=%b exp 1 0 00000000 0", bus4.in_ready, bus4.out_valid, bus4.sum, bus4.cout);
    end
    av = $urandom; bv = $urandom;
    r = ref_add32(av, bv, 1'b1);
    run_op(av, bv, 1'b1, lat, s, co);
    checks++; if ({co, s} !== r || lat !== 4) begin errors++; $display("FAIL mid_fresh got=%b/%h lat=%0d exp=%b/%h lat=4", co, s, lat, r[32], r[31:0]); end
    release_out();
  endtask

  task automatic test_random;
    int lat; logic [31:0] s; logic co; logic [31:0] av, bv; logic cv; logic [32:0] r;
    for (int i = 0; i < 20; i++) begin
      av = $urandom; bv = $urandom; cv = 1'($urandom_range(0, 1));
      if (i == 0) begin av = 32'h0; bv = 32'h0; cv = 1'b0; end
      if (i == 1) begin av = 32'hFFFF_FFFF; bv = 32'hFFFF_FFFF; cv = 1'b1; end
      r = ref_add32(av, bv, cv);
      run_op(av, bv, cv, lat, s, co);
      checks++;
      if ({co, s} !== r || lat !== 4) begin
        errors++;
        $display("FAIL rand_%0d a=%h b=%h cin=%b got=%b/%h lat=%0d exp=%b/%h lat=4", i, av, bv, cv, co, s, lat, r[32], r[31:0]);
      end
`ifdef LSA_OVF_EN
      checks++; if (bus4.ovf !== ref_ovf32(av, bv, cv)) begin errors++; $display("FAIL rand_ovf_%0d got=%b exp=%b", i, bus4.ovf, ref_ovf32(av, bv, cv)); end
`endif
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
      release_out();
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] qa [3]; logic [31:0] qb [3]; logic qc [3];
    int acc [3]; int k, r, cyc; logic [32:0] e;
    for (int i = 0; i < 3; i++) begin qa[i] = $urandom; qb[i] = $urandom; qc[i] = 1'($urandom_range(0, 1)); acc[i] = 0; end
    k = 0; r = 0; cyc = 0;
    bus4.out_ready = 1'b1;
    while (r < 3 && cyc < 100) begin
      if (bus4.out_valid === 1'b1) begin
        e = ref_add32(qa[r], qb[r], qc[r]);
        checks++; if ({bus4.cout, bus4.sum} !== e) begin errors++; $display("FAIL b2b_result_%0d got=%b/%h exp=%b/%h", r, bus4.cout, bus4.sum, e[32], e[31:0]); end
        r++;
      end
      if (bus4.in_ready === 1'b1 && k < 3) begin
        bus4.a = qa[k]; bus4.b = qb[k]; bus4.cin = qc[k]; bus4.in_valid = 1'b1;
        acc[k] = cyc + 1; k++;
      end else begin
        bus4.in_valid = 1'b0;
      end
      tick(); cyc++;
    end
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    checks++; if (r !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", r); end
    checks++; if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin errors++; $display("FAIL b2b_interval got=%0d,%0d exp=6,6", acc[1] - acc[0], acc[2] - acc[1]); end
  endtask

`ifdef LSA_OVF_EN
  task automatic test_overflow;
    int lat; logic [31:0] s; logic co;
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, lat, s, co);
    checks++; if (bus4.ovf !== 1'b1 || s !== 32'h8000_0000) begin errors++; $display("FAIL ovf_pos got ovf=%b sum=%h exp ovf=1 sum=80000000", bus4.ovf, s); end
    release_out();
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, lat, s, co);
    checks++; if (bus4.ovf !== 1'b0 || co !== 1'b1) begin errors++; $display("FAIL ovf_neg got ovf=%b cout=%b exp ovf=0 cout=1", bus4.ovf, co); end
    release_out();
  endtask
`endif

  task automatic test_limbs_one;
    logic [7:0] av, bv; logic cv; logic [8:0] r; int lat;
    for (int i = 0; i < 8; i++) begin
      av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom_range(0, 1));
      if (i == 0) begin av = 8'hFF; bv = 8'h01; cv = 1'b0; end
      r = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
      bus1.a = av; bus1.b = bv; bus1.cin = cv; bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      lat = 0;
      while (bus1.out_valid !== 1'b1 && lat < 16) begin tick(); lat++; end
      checks++;
      if ({bus1.cout, bus1.sum} !== r || lat !== 1) begin
        errors++;
        $display("FAIL l1_%0d a=%h b=%h cin=%b got=%b/%h lat=%0d exp=%b/%h lat=1", i, av, bv, cv, bus1.cout, bus1.sum, lat, r[8], r[7:0]);
      end
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_carry_in();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef LSA_OVF_EN
    test_overflow();
`endif
    test_limbs_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
